// File: rtl/onehot_reg_file.sv
// 32 x WIDTH register file written through a one-hot enable, with index encoding, written bitmap and multi-hot error.
// Optional macro RF_WRITE_FORWARD_EN adds same-cycle write-through to both read ports.
module onehot_reg_file #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [DEPTH-1:0]         we_onehot,
    input  logic [WIDTH-1:0]         wd,
    input  logic [$clog2(DEPTH)-1:0] ra1,
    input  logic [$clog2(DEPTH)-1:0] ra2,
    output logic [WIDTH-1:0]         rd1,
    output logic [WIDTH-1:0]         rd2,
    output logic [$clog2(DEPTH)-1:0] last_wa,
    output logic [DEPTH-1:0]         written,
    output logic                     enc_err
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [AW-1:0]    enc_idx;
    logic             we_any;
    logic             multi_hot;
    logic             we_valid;

    // Popcount check kept apart from the encoder: clearing the lowest set bit leaves zero only for one-hot.
    assign we_any    = |we_onehot;
    assign multi_hot = |(we_onehot & (we_onehot - DEPTH'(1)));
    assign we_valid  = we_any && !multi_hot;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        enc_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            enc_idx = enc_idx | (we_onehot[i] ? AW'(i) : '0);
        end
    end

    // NOTE: the array is in the reset branch because reset must clear every register; state uses <= only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            last_wa <= '0;
            written <= '0;
            enc_err <= 1'b0;
        end else begin
            if (multi_hot) begin
                enc_err <= 1'b1;
            end else if (we_valid) begin
                last_wa          <= enc_idx;
                written[enc_idx] <= 1'b1;
                // Register 0 is hardwired: accepted as a write but never stored.
                for (int i = 1; i < DEPTH; i++) begin
                    if (we_onehot[i]) begin
                        regs[i] <= wd;
                    end
                end
            end
        end
    end

    always_comb begin
        rd1 = regs[ra1];
`ifdef RF_WRITE_FORWARD_EN
        if (we_valid && we_onehot[ra1] && (ra1 != '0)) begin
            rd1 = wd;
        end
`endif
    end

    always_comb begin
        rd2 = regs[ra2];
`ifdef RF_WRITE_FORWARD_EN
        if (we_valid && we_onehot[ra2] && (ra2 != '0)) begin
            rd2 = wd;
        end
`endif
    end

endmodule

// File: tb/tb_onehot_reg_file.sv
// Scoreboard bench for onehot_reg_file: a behavioural model queues expected values, which are popped and compared on sampling.
module tb_onehot_reg_file;

    typedef enum logic [2:0] {OBS_RD1, OBS_RD2, OBS_LAST_WA, OBS_WRITTEN, OBS_ENC_ERR} obs_e;

    typedef struct {
        string       tag;
        obs_e        kind;
        logic [31:0] value;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] we_onehot = '0;
    logic [31:0] wd = '0;
    logic [4:0]  ra1 = '0;
    logic [4:0]  ra2 = '0;
    logic [31:0] rd1, rd2;
    logic [4:0]  last_wa;
    logic [31:0] written;
    logic        enc_err;

    int vectors = 0;
    int miscompares = 0;

    exp_t        sb[$];
    logic [31:0] mem_m [32];
    logic [4:0]  last_wa_m;
    logic [31:0] written_m;
    logic        enc_err_m;

    onehot_reg_file #(.WIDTH(32), .DEPTH(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .we_onehot (we_onehot),
        .wd        (wd),
        .ra1       (ra1),
        .ra2       (ra2),
        .rd1       (rd1),
        .rd2       (rd2),
        .last_wa   (last_wa),
        .written   (written),
        .enc_err   (enc_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input obs_e kind, input logic [31:0] value);
        exp_t e;
        e.tag = tag;
        e.kind = kind;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                OBS_RD1:     obs = rd1;
                OBS_RD2:     obs = rd2;
                OBS_LAST_WA: obs = {27'd0, last_wa};
                OBS_WRITTEN: obs = written;
                default:     obs = {31'd0, enc_err};
            endcase
            check(e.tag, obs, e.value);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem_m[i] = '0;
        last_wa_m = '0;
        written_m = '0;
        enc_err_m = 1'b0;
    endtask

    task automatic model_write(input logic [31:0] we, input logic [31:0] data);
        if ($countones(we) == 1) begin
            for (int i = 0; i < 32; i++) begin
                if (we[i]) begin
                    if (i != 0) mem_m[i] = data;
                    last_wa_m = 5'(i);
                    written_m[i] = 1'b1;
                end
            end
        end else if ($countones(we) > 1) begin
            enc_err_m = 1'b1;
        end
    endtask

    task automatic do_write(input logic [31:0] we, input logic [31:0] data);
        @(negedge clk);
        we_onehot = we;
        wd = data;
        @(posedge clk);
        model_write(we, data);
        #1;
        we_onehot = '0;
    endtask

    task automatic read_check(input string tag, input logic [4:0] a1, input logic [4:0] a2);
        ra1 = a1;
        ra2 = a2;
        #2;
        expect_val({tag, "_rd1"}, OBS_RD1, mem_m[a1]);
        expect_val({tag, "_rd2"}, OBS_RD2, mem_m[a2]);
        drain();
    endtask

    task automatic status_check(input string tag);
        #1;
        expect_val({tag, "_last_wa"}, OBS_LAST_WA, {27'd0, last_wa_m});
        expect_val({tag, "_written"}, OBS_WRITTEN, written_m);
        expect_val({tag, "_enc_err"}, OBS_ENC_ERR, {31'd0, enc_err_m});
        drain();
    endtask

    initial begin
        model_reset();
        // Preload a nonzero reg so reset is seen to clear it.
        reset_n = 1'b1;
        do_write(32'h1 << 5, 32'hCAFE0005);
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 32; i++) read_check("reset_sweep", 5'(i), 5'(31 - i));
        status_check("reset");

        for (int i = 1; i < 32; i++) do_write(32'h1 << i, 32'hA500_0000 + 32'(i));
        for (int i = 1; i < 32; i++) read_check("write_sweep", 5'(i), 5'(32 - i));
        status_check("write_sweep");
        expect_val("sweep_last_wa_const", OBS_LAST_WA, 32'd31);
        expect_val("sweep_written_const", OBS_WRITTEN, 32'hFFFF_FFFE);
        drain();

        do_write(32'h0000_0001, 32'hDEAD_BEEF);
        read_check("x0_write", 5'd0, 5'd0);
        status_check("x0_write");
        expect_val("x0_rd_zero", OBS_RD1, 32'h0);
        drain();

        do_write(32'h0, 32'h1111_1111);
        status_check("no_write");
        read_check("no_write", 5'd1, 5'd31);

        do_write(32'h0000_0014, 32'h1234_5678);
        read_check("multi_hot", 5'd2, 5'd4);
        status_check("multi_hot");
        expect_val("multi_hot_err", OBS_ENC_ERR, 32'h1);
        drain();
        do_write(32'h1 << 3, 32'h0000_0033);
        read_check("after_err", 5'd3, 5'd2);
        status_check("after_err");
        expect_val("after_err_rd", OBS_RD1, 32'h33);
        drain();

        // Back-to-back writes on consecutive cycles.
        for (int i = 10; i < 14; i++) do_write(32'h1 << i, $urandom);
        read_check("b2b", 5'd10, 5'd13);
        read_check("b2b", 5'd11, 5'd12);
        status_check("b2b");

        // Same-cycle read and write of reg 7.
        @(negedge clk);
        ra1 = 5'd7;
        ra2 = 5'd0;
        we_onehot = 32'h1 << 7;
        wd = 32'h55;
        #1;
`ifdef RF_WRITE_FORWARD_EN
        expect_val("rw7_before_edge", OBS_RD1, 32'h55);
`else
        expect_val("rw7_before_edge", OBS_RD1, mem_m[7]);
`endif
        expect_val("rw7_x0_no_fwd", OBS_RD2, 32'h0);
        drain();
        @(posedge clk);
        model_write(32'h1 << 7, 32'h55);
        #1;
        we_onehot = '0;
        expect_val("rw7_after_edge", OBS_RD1, 32'h55);
        drain();

        // Reset asserted while a write to reg 9 is presented.
        @(negedge clk);
        ra1 = 5'd9;
        ra2 = 5'd7;
        we_onehot = 32'h1 << 9;
        wd = 32'h9999_9999;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        expect_val("midreset_rd9", OBS_RD1, 32'h0);
        expect_val("midreset_rd7", OBS_RD2, 32'h0);
        drain();
        status_check("midreset");
        @(posedge clk);
        @(negedge clk);
        we_onehot = '0;
        reset_n = 1'b1;
        read_check("post_reset", 5'd9, 5'd3);
        status_check("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
